voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice controller for the synth wave-generator bank. Accepts key press/release events over a valid/ready handshake and assigns each note to one of `NUM_VOICES` generator slots. It drives each slot's frequency and amplitude inputs, stealing the oldest voice when all slots are busy. On release it ramps a voice's amplitude down linearly, then frees the slot. It sits between the key-scan/MIDI front end and the square/other wave generators, whose outputs feed the mixer.

## Interface
- `NUM_VOICES`, 4: number of generator slots (2..8).
- `RELEASE_STEP_CYCLES`, 500000: clk cycles per 1-LSB amplitude decrement during release (10 ms at 50 MHz).
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  reset, synchronous, active-low.
- `key_valid`  in  1  event present.
- `key_ready`  out  1  block can accept an event this cycle.
- `key_on`  in  1  1 = press, 0 = release.
- `key_freq`  in  16  note frequency in Hz; also the note identity.
- `key_amp`  in  6  peak amplitude for a press; ignored for a release.
- `voice_freq`  out  16*NUM_VOICES  slot i at bits [16*i +: 16]; 0 = silent, because generators mute at frequency 0.
- `voice_amp`  out  6*NUM_VOICES  slot i at bits [6*i +: 6].
- `voice_active`  out  NUM_VOICES  slot state is not IDLE.

## Operation
- **Per-slot state:** IDLE, HELD, RELEASE. Each slot also holds `freq`, `amp` and `rank`.
- **Rank** is a permutation of 0..N-1, where 0 is the newest slot. Reset value: `rank[i] = i`.
- **Control FSM:** two states, S_WAIT and S_APPLY.
  - S_WAIT: `key_ready` = 1. When `key_valid` and `key_ready` are both high, latch `key_on`/`key_freq`/`key_amp` and go to S_APPLY.
  - S_APPLY: `key_ready` = 0. Update slots from the latched event, then return to S_WAIT.
- **Press, with `freq` ≠ 0 and `amp` ≠ 0.** Pick the target slot in this order:
  1. A slot in HELD or RELEASE whose `freq` matches (retrigger).
  2. Otherwise, the lowest-index IDLE slot.
  3. Otherwise, the slot with `rank` N-1 (steal).
- **Press effect on the target:** `freq` = `key_freq`, `amp` = `key_amp`, state = HELD.
- **Rank update on press:** the target's rank becomes 0. Every slot whose rank was below the target's old rank increments by 1.
- **Press with `freq` = 0 or `amp` = 0:** accepted, no effect.
- **Release:** a HELD slot with matching `freq` goes to RELEASE; `amp` and `freq` are unchanged. If there is no HELD match, the event is accepted and has no effect. Ranks are unchanged.
- **Prescaler:** free-running counter 0..`RELEASE_STEP_CYCLES`-1. `tick` is high when the counter is at max. Reset value is 0.
- **On tick, each RELEASE slot:**
  - If `amp` > 1: `amp` decrements by 1.
  - If `amp` is 1 or 0: `amp` = 0, `freq` = 0, state = IDLE. Rank is kept.
- **Tick and event on the same cycle, same slot:** the event wins and the tick is skipped for that slot. Other slots still take the tick.
- **Distinct-freq invariant:** at most one non-IDLE slot holds a given `freq`, guaranteed by the retrigger rule.

## Timing
- **Reset values:**
  - `key_ready` = 1.
  - `voice_freq` = 0, `voice_amp` = 0, `voice_active` = 0.
  - FSM in S_WAIT, prescaler = 0, all slots IDLE.
- **Handshake:**
  - An event is accepted at edge N.
  - `key_ready` is low for the cycle after edge N.
  - Slot outputs change at edge N+1.
  - `key_ready` is high again after edge N+1.
  - Maximum throughput is one event per 2 cycles.
- **Outputs:** all are registered; no combinational path from the `key_*` inputs to the outputs.
- **Release ramp:** from amplitude A to IDLE takes exactly A ticks. The first decrement happens at the first tick after entering RELEASE.
- **Reset mid-operation:** all slots clear on the next edge and any latched event is discarded.

## Structure
- **Package `synth_pkg`:**
  - `voice_state_t` enum {IDLE, HELD, RELEASE}.
  - `FREQ_W`=16, `AMP_W`=6.
  - `CLOCK_FREQUENCY`=50000000; the generators share this constant.
- **Sub-module `voice_slot`:** holds one slot's state, `freq`, `amp`, `rank` and the release decrement.
  - Inputs: a load/retrigger strobe, a release strobe, `rank` controls, `tick`.
  - Outputs: match flags for a given `freq`.
  - The top level instantiates `NUM_VOICES` of these and contains the FSM, prescaler, target selection and rank arbitration.

## Test plan
All scenarios use `RELEASE_STEP_CYCLES`=4 and `NUM_VOICES`=4.
- **Reset:** hold `reset_n` low for 3 cycles → all outputs 0, `key_ready`=1.
- **Press 440/amp 20:** → slot 0 shows freq 440, amp 20, active; `key_ready` is low for exactly one cycle.
- **Press 440, 494, 523, 587, then 659:**
  - The first four fill slots 0..3.
  - 659 steals slot 0, the oldest.
  - Then press 494 again with amp 10 → slot 1 retriggers to amp 10 with no new allocation.
- **Press 440/amp 3, then release 440:**
  - amp steps 3→2→1 at consecutive ticks, 4 cycles apart.
  - At the third tick, freq=0 and active=0.
  - Also check: release of an unheld 300 → no change.
- **Release 440 (amp 5); re-press 440/amp 12 on the tick cycle:** → amp=12, HELD, no decrement.
- **Edge events:** press with freq 0, and press with amp 0 → both accepted, no slot change. Assert reset mid-release → slot cleared next edge.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and types for the synth voice path.
// Generators and the voice allocator both import this package.
package synth_pkg;

    localparam int FREQ_W          = 16;
    localparam int AMP_W           = 6;
    localparam int CLOCK_FREQUENCY = 50000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        RELEASE = 2'd2
    } voice_state_t;

endpackage

// File: rtl/voice_slot.sv
// One generator slot: holds the note state, frequency, amplitude and age rank,
// and applies the linear release decay on each prescaler tick.
module voice_slot
    import synth_pkg::*;
#(
    parameter int RANK_W     = 2,
    parameter int RESET_RANK = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_release,
    input  logic              i_rank_zero,
    input  logic              i_rank_inc,
    input  logic              i_tick,
    input  logic [FREQ_W-1:0] i_key_freq,
    input  logic [AMP_W-1:0]  i_key_amp,
    output logic              o_match_active,
    output logic              o_match_held,
    output logic              o_idle,
    output logic [RANK_W-1:0] o_rank,
    output logic [FREQ_W-1:0] o_freq,
    output logic [AMP_W-1:0]  o_amp,
    output logic              o_active
);

    voice_state_t      r_state;
    logic [FREQ_W-1:0] r_freq;
    logic [AMP_W-1:0]  r_amp;
    logic [RANK_W-1:0] r_rank;

    // An event on this slot takes precedence over a coincident tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_freq  <= '0;
            r_amp   <= '0;
            r_rank  <= RANK_W'(RESET_RANK);
        end else begin
            if (i_load) begin
                r_state <= HELD;
                r_freq  <= i_key_freq;
                r_amp   <= i_key_amp;
            end else if (i_release) begin
                r_state <= RELEASE;
            end else if (i_tick && (r_state == RELEASE)) begin
                if (r_amp > AMP_W'(1)) begin
                    r_amp <= r_amp - 1'b1;
                end else begin
                    r_amp   <= '0;
                    r_freq  <= '0;
                    r_state <= IDLE;
                end
            end

            if (i_rank_zero) begin
                r_rank <= '0;
            end else if (i_rank_inc) begin
                r_rank <= r_rank + 1'b1;
            end
        end
    end

    always_comb begin
        o_match_active = (r_state != IDLE) && (r_freq == i_key_freq);
        o_match_held   = (r_state == HELD) && (r_freq == i_key_freq);
        o_idle         = (r_state == IDLE);
        o_active       = (r_state != IDLE);
        o_rank         = r_rank;
        o_freq         = r_freq;
        o_amp          = r_amp;
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts key events, assigns notes to generator
// slots (retrigger, then free slot, then steal oldest) and runs release decay.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES          = 4,
    parameter int RELEASE_STEP_CYCLES = 500000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         key_valid,
    output logic                         key_ready,
    input  logic                         key_on,
    input  logic [FREQ_W-1:0]            key_freq,
    input  logic [AMP_W-1:0]             key_amp,
    output logic [FREQ_W*NUM_VOICES-1:0] voice_freq,
    output logic [AMP_W*NUM_VOICES-1:0]  voice_amp,
    output logic [NUM_VOICES-1:0]        voice_active
);

    localparam int unsigned NV      = NUM_VOICES;
    localparam int          RANK_W  = $clog2(NUM_VOICES);
    localparam int          PRESC_W = (RELEASE_STEP_CYCLES > 1) ? $clog2(RELEASE_STEP_CYCLES) : 1;

    localparam logic [0:0]         S_WAIT      = 1'b0;
    localparam logic [0:0]         S_APPLY     = 1'b1;
    localparam logic [RANK_W-1:0]  RANK_OLDEST = RANK_W'(NUM_VOICES - 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX   = PRESC_W'(RELEASE_STEP_CYCLES - 1);

    logic [0:0]         r_state;
    logic               r_key_on;
    logic [FREQ_W-1:0]  r_key_freq;
    logic [AMP_W-1:0]   r_key_amp;
    logic [PRESC_W-1:0] r_presc;

    logic               w_tick;
    logic               w_press;
    logic               w_rel;
    logic               w_hit_any;
    logic               w_idle_any;
    logic [RANK_W-1:0]  w_hit_idx;
    logic [RANK_W-1:0]  w_idle_idx;
    logic [RANK_W-1:0]  w_old_idx;
    logic [RANK_W-1:0]  w_tgt;
    logic [RANK_W-1:0]  w_tgt_rank;

    logic [NUM_VOICES-1:0] w_match_active;
    logic [NUM_VOICES-1:0] w_match_held;
    logic [NUM_VOICES-1:0] w_idle;
    logic [NUM_VOICES-1:0] w_load;
    logic [NUM_VOICES-1:0] w_release;
    logic [NUM_VOICES-1:0] w_rank_inc;
    logic [RANK_W-1:0]     w_rank [NUM_VOICES];

    assign w_tick    = (r_presc == PRESC_MAX);
    assign key_ready = (r_state == S_WAIT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_WAIT;
            r_key_on   <= 1'b0;
            r_key_freq <= '0;
            r_key_amp  <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (key_valid) begin
                        r_key_on   <= key_on;
                        r_key_freq <= key_freq;
                        r_key_amp  <= key_amp;
                        r_state    <= S_APPLY;
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    // Target priority: retrigger a sounding note, else lowest free slot, else oldest.
    always_comb begin
        w_press    = (r_state == S_APPLY) && r_key_on && (r_key_freq != '0) && (r_key_amp != '0);
        w_rel      = (r_state == S_APPLY) && !r_key_on;
        w_hit_any  = 1'b0;
        w_idle_any = 1'b0;
        w_hit_idx  = '0;
        w_idle_idx = '0;
        w_old_idx  = '0;
        for (int unsigned i = 0; i < NV; i++) begin
            if (w_match_active[i] && !w_hit_any) begin
                w_hit_any = 1'b1;
                w_hit_idx = RANK_W'(i);
            end
            if (w_idle[i] && !w_idle_any) begin
                w_idle_any = 1'b1;
                w_idle_idx = RANK_W'(i);
            end
            if (w_rank[i] == RANK_OLDEST) begin
                w_old_idx = RANK_W'(i);
            end
        end
        if (w_hit_any) begin
            w_tgt = w_hit_idx;
        end else if (w_idle_any) begin
            w_tgt = w_idle_idx;
        end else begin
            w_tgt = w_old_idx;
        end
        w_tgt_rank = w_rank[w_tgt];
    end

    always_comb begin
        w_load     = '0;
        w_release  = '0;
        w_rank_inc = '0;
        for (int unsigned i = 0; i < NV; i++) begin
            w_load[i]     = w_press && (w_tgt == RANK_W'(i));
            w_rank_inc[i] = w_press && (w_rank[i] < w_tgt_rank);
            w_release[i]  = w_rel && w_match_held[i];
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_slot #(
            .RANK_W     (RANK_W),
            .RESET_RANK (g)
        ) u_slot (
            .clk            (clk),
            .reset_n        (reset_n),
            .i_load         (w_load[g]),
            .i_release      (w_release[g]),
            .i_rank_zero    (w_load[g]),
            .i_rank_inc     (w_rank_inc[g]),
            .i_tick         (w_tick),
            .i_key_freq     (r_key_freq),
            .i_key_amp      (r_key_amp),
            .o_match_active (w_match_active[g]),
            .o_match_held   (w_match_held[g]),
            .o_idle         (w_idle[g]),
            .o_rank         (w_rank[g]),
            .o_freq         (voice_freq[FREQ_W*g +: FREQ_W]),
            .o_amp          (voice_amp[AMP_W*g +: AMP_W]),
            .o_active       (voice_active[g])
        );
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with 4 voices and a 4-cycle release step.
module tb_voice_allocator;

    localparam int N    = 4;
    localparam int STEP = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          key_valid;
    logic          key_ready;
    logic          key_on;
    logic [15:0]   key_freq;
    logic [5:0]    key_amp;
    logic [16*N-1:0] voice_freq;
    logic [6*N-1:0]  voice_amp;
    logic [N-1:0]    voice_active;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    voice_allocator #(
        .NUM_VOICES          (N),
        .RELEASE_STEP_CYCLES (STEP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_on       (key_on),
        .key_freq     (key_freq),
        .key_amp      (key_amp),
        .voice_freq   (voice_freq),
        .voice_amp    (voice_amp),
        .voice_active (voice_active)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; prescaler phase is cyc % STEP.
    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fq(input int i);
        return voice_freq[16*i +: 16];
    endfunction

    function automatic logic [5:0] am(input int i);
        return voice_amp[6*i +: 6];
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_freq", voice_freq, 64'd0);
        check("rst_amp", voice_amp, 64'd0);
        check("rst_active", voice_active, 64'd0);
        check("rst_ready", key_ready, 64'd1);
        reset_n = 1'b1;
    endtask

    task automatic send(input logic on, input logic [15:0] f, input logic [5:0] a);
        int n = 0;
        key_valid = 1'b1;
        key_on    = on;
        key_freq  = f;
        key_amp   = a;
        while (!key_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", key_ready, 64'd1);
        @(negedge clk);
        key_valid = 1'b0;
        check("ready_low", key_ready, 64'd0);
        @(negedge clk);
        check("ready_high", key_ready, 64'd1);
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while ((cyc % STEP) != p && n < 8) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_on    = 1'b0;
        key_freq  = '0;
        key_amp   = '0;

        // Single press
        do_reset();
        send(1'b1, 16'd440, 6'd20);
        check("p1_freq0", fq(0), 64'd440);
        check("p1_amp0", am(0), 64'd20);
        check("p1_active", voice_active, 64'b0001);
        check("p1_freq_rest", voice_freq[63:16], 64'd0);

        // Fill, steal, retrigger, steal again
        do_reset();
        send(1'b1, 16'd440, 6'd20);
        send(1'b1, 16'd494, 6'd21);
        send(1'b1, 16'd523, 6'd22);
        send(1'b1, 16'd587, 6'd23);
        check("fill_freq", voice_freq, {16'd587, 16'd523, 16'd494, 16'd440});
        check("fill_amp", voice_amp, {6'd23, 6'd22, 6'd21, 6'd20});
        check("fill_active", voice_active, 64'hF);
        send(1'b1, 16'd659, 6'd30);
        check("steal_freq", voice_freq, {16'd587, 16'd523, 16'd494, 16'd659});
        check("steal_amp0", am(0), 64'd30);
        send(1'b1, 16'd494, 6'd10);
        check("retrig_freq", voice_freq, {16'd587, 16'd523, 16'd494, 16'd659});
        check("retrig_amp", voice_amp, {6'd23, 6'd22, 6'd10, 6'd30});
        send(1'b1, 16'd700, 6'd5);
        check("steal2_freq", voice_freq, {16'd587, 16'd700, 16'd494, 16'd659});
        check("steal2_amp2", am(2), 64'd5);

        // Release ramp
        do_reset();
        send(1'b1, 16'd440, 6'd3);
        send(1'b0, 16'd300, 6'd0);
        check("rel_unheld_freq", fq(0), 64'd440);
        check("rel_unheld_amp", am(0), 64'd3);
        wait_phase(0);
        send(1'b0, 16'd440, 6'd0);
        check("rel_start_amp", am(0), 64'd3);
        check("rel_start_active", voice_active, 64'b0001);
        @(negedge clk);
        check("rel_pre_tick", am(0), 64'd3);
        @(negedge clk);
        check("rel_tick1", am(0), 64'd2);
        repeat (3) @(negedge clk);
        check("rel_hold2", am(0), 64'd2);
        @(negedge clk);
        check("rel_tick2", am(0), 64'd1);
        check("rel_tick2_freq", fq(0), 64'd440);
        repeat (4) @(negedge clk);
        check("rel_tick3_amp", am(0), 64'd0);
        check("rel_tick3_freq", fq(0), 64'd0);
        check("rel_tick3_active", voice_active, 64'd0);

        // Re-press on the tick cycle; other releasing slot still decays
        do_reset();
        send(1'b1, 16'd440, 6'd5);
        send(1'b1, 16'd600, 6'd9);
        wait_phase(0);
        send(1'b0, 16'd600, 6'd0);
        check("coll_a1_start", am(1), 64'd9);
        @(negedge clk);
        @(negedge clk);
        check("coll_a1_tick", am(1), 64'd8);
        send(1'b0, 16'd440, 6'd0);
        check("coll_a0_rel", am(0), 64'd5);
        check("coll_a1_hold", am(1), 64'd8);
        send(1'b1, 16'd440, 6'd12);
        check("coll_a0_repress", am(0), 64'd12);
        check("coll_f0_repress", fq(0), 64'd440);
        check("coll_a1_other", am(1), 64'd7);
        repeat (8) @(negedge clk);
        check("coll_a0_held", am(0), 64'd12);
        check("coll_a1_later", am(1), 64'd5);

        // Null presses and reset mid-release with an event in flight
        do_reset();
        send(1'b1, 16'd0, 6'd10);
        check("null_f_freq", voice_freq, 64'd0);
        check("null_f_active", voice_active, 64'd0);
        send(1'b1, 16'd500, 6'd0);
        check("null_a_freq", voice_freq, 64'd0);
        check("null_a_active", voice_active, 64'd0);
        send(1'b1, 16'd440, 6'd4);
        wait_phase(0);
        send(1'b0, 16'd440, 6'd0);
        @(negedge clk);
        @(negedge clk);
        check("mid_amp", am(0), 64'd3);
        key_valid = 1'b1;
        key_on    = 1'b1;
        key_freq  = 16'd800;
        key_amp   = 6'd7;
        @(negedge clk);
        key_valid = 1'b0;
        check("mid_latched", key_ready, 64'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_freq", voice_freq, 64'd0);
        check("mid_rst_amp", voice_amp, 64'd0);
        check("mid_rst_active", voice_active, 64'd0);
        check("mid_rst_ready", key_ready, 64'd1);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_discard_freq", voice_freq, 64'd0);
        check("mid_discard_active", voice_active, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
